systolic_wt_stationary_ctrl: RTL
================================

# systolic_wt_stationary_ctrl

Sequencer for a ROWS×COLS weight-stationary MAC array. Each MAC has a `control` input: high loads and shifts weights down a column; low streams activations right and accumulations down. For one job the block:
- asserts the array `control` for exactly ROWS cycles while addressing the weight buffer in reverse row order;
- feeds `num_vec` activation vectors into the array rows with a one-cycle-per-row skew;
- flags which bottom-row accumulator outputs are valid, and which vector each belongs to.

It sits between the convolution-layer top, which issues `start`, and the array wrapper plus its weight and activation buffers.

## Interface
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥2)
- IDX_W, 16, vector-index width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; honoured only in IDLE
- num_vec  in  IDX_W  vectors in the job; latched when `start` is accepted
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse in the DONE state
- array_control  out  1  drives the `control` input of every MAC
- wt_rd_row  out  clog2(ROWS)  weight-buffer row address; the buffer is combinational-read, and its data goes to the top-row weight path in the same cycle
- act_valid  out  ROWS  per-row activation valid; when low, the wrapper drives 0 onto that row's data input
- act_rd_idx  out  ROWS*IDX_W  per-row vector index (row r at bits [r*IDX_W +: IDX_W]); combinational-read buffer
- out_valid  out  COLS  bottom-row `acc_out` of column c holds a finished dot product
- out_idx  out  COLS*IDX_W  vector index of each valid output

## Operation
- **States:** IDLE, LOAD_W, STREAM, DRAIN, DONE.
- **IDLE → LOAD_W:** on `start`; latch `num_vec`; clear the counter.
- **LOAD_W:** lasts ROWS cycles, l = 0..ROWS-1.
  - `array_control`=1 and `wt_rd_row`=ROWS-1-l, so row 0's weights are the last ones shifted in.
  - Then → STREAM, or → DONE if `num_vec`=0.
- **STREAM/DRAIN:** a single step counter s runs from 0 to S_END = num_vec+ROWS+COLS-2.
  - The state is STREAM while s < num_vec+ROWS-1, and DRAIN afterwards.
  - `array_control`=0 throughout.
- **Activation feed:**
  - act_valid[r] = (s ≥ r) && (s-r < num_vec).
  - act_rd_idx[r] = s-r when valid, else 0.
- **Output capture:**
  - out_valid[c] = (s ≥ ROWS+c) && (s-ROWS-c < num_vec).
  - out_idx[c] = s-ROWS-c when valid, else 0.
- **After S_END:** → DONE for one cycle (`done`=1, `busy`=1), then → IDLE.
- **`start` outside IDLE:** ignored, including in the DONE cycle.
- **Top-row `acc_in`:** the wrapper ties it to 0; this block does not drive it.
- **Counter width:** IDX_W+2 bits, so S_END never wraps for num_vec up to 2^IDX_W-1.

## Timing
- **Reset:**
  - All outputs go to 0 on the edge where `rst`=1, and the state goes to IDLE.
  - Reset has priority over `start` and over any in-flight job.
  - The aborted job produces no `done`.
- **Example:** `start` is sampled at edge E.
  - LOAD_W occupies cycles E+1 .. E+ROWS.
  - s=0 falls in cycle E+ROWS+1.
- **Array relationships:**
  - A vector fed at row r in step s reaches MAC(r,c) at step s+c.
  - Its result leaves the bottom row of column c during step k+ROWS+c, where k is the vector index.
- **Latency:** from `start` to `done` is ROWS + (num_vec+ROWS+COLS-1) + 1 cycles. For num_vec=0 it is ROWS+1.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs.

## Test plan
- **Single vector** (ROWS=COLS=4, num_vec=1, `start` at cycle 0):
  - `busy` rises at cycle 1.
  - `array_control` is high in cycles 1–4, with `wt_rd_row` = 3, 2, 1, 0.
  - act_valid[r] is high at cycle 5+r.
  - out_valid[c] is high at cycle 9+c.
  - `done` is high at cycle 13, and `busy` is low at cycle 14.
- **End-to-end with a behavioural MAC array:**
  - num_vec=5, weights W[r][c]=r+c+1, activations x[k][r]=k+r.
  - Each captured output must equal Σ_r x[k][r]·W[r][c], tagged with the matching out_idx=k.
  - There are exactly 20 out_valid pulses.
- **`start` held high throughout a num_vec=3 job:**
  - Exactly one job runs; the `start` seen in the DONE cycle is ignored.
  - The next job begins at the following IDLE cycle.
- **num_vec=0:**
  - LOAD_W runs for 4 cycles, then `done`.
  - `act_valid` and `out_valid` never assert.
- **Reset mid-job:**
  - Assert `rst` at s=2 of a num_vec=8 job.
  - On the next cycle all outputs are 0 and the block is in IDLE, with no `done`.
  - A new `start` then runs a correct full job.
- **Large count:** num_vec=2^IDX_W-1 (IDX_W=4, so 15).
  - The final out_valid[3] carries out_idx=14.
  - The counter does not wrap, and `done` follows one cycle later.

Source files
------------

// File: rtl/systolic_wt_stationary_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_wt_stationary_ctrl
// Purpose  : Job sequencer for a ROWS x COLS weight-stationary MAC array.
//            A job first shifts ROWS weight rows into the array, bottom row
//            first. It then streams num_vec activation vectors into the rows
//            with a one-cycle-per-row skew. It flags which bottom-row
//            accumulator outputs hold finished dot products, and which
//            vector each one belongs to.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start_i, num_vec_i - job request and vector count (IDLE only)
//            busy_o, done_o     - job in flight / one-cycle completion pulse
//            array_control_o    - MAC control (1 = weight load/shift)
//            wt_rd_row_o        - weight buffer row address
//            act_valid_o        - per-row activation valid
//            act_rd_idx_o       - per-row activation vector index
//            out_valid_o        - per-column bottom-row result valid
//            out_idx_o          - per-column result vector index
// Revision : 1.0 - initial release
// ============================================================================
module systolic_wt_stationary_ctrl #(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int IDX_W = 16,
    localparam int RAW_W = $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [IDX_W-1:0]        num_vec_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    array_control_o,
    output logic [RAW_W-1:0]        wt_rd_row_o,
    output logic [ROWS-1:0]         act_valid_o,
    output logic [ROWS*IDX_W-1:0]   act_rd_idx_o,
    output logic [COLS-1:0]         out_valid_o,
    output logic [COLS*IDX_W-1:0]   out_idx_o
);

    // Two extra bits so num_vec + ROWS + COLS - 2 never wraps.
    localparam int CNT_W = IDX_W + 2;

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ROWS    = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] C_ROWS_M1 = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] C_RC2     = CNT_W'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       nv_q, nv_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ctrl_q, ctrl_d;
    logic [RAW_W-1:0]       wt_q, wt_d;
    logic [ROWS-1:0]        av_q, av_d;
    logic [ROWS*IDX_W-1:0]  ai_q, ai_d;
    logic [COLS-1:0]        ov_q, ov_d;
    logic [COLS*IDX_W-1:0]  oi_q, oi_d;

    logic [CNT_W-1:0]       w_nv_ext;
    logic [CNT_W-1:0]       w_nvd_ext;
    logic [CNT_W-1:0]       w_s_end;
    logic [CNT_W-1:0]       w_stream_end;
    logic [CNT_W-1:0]       w_diff;

    assign w_nv_ext     = {2'b00, nv_q};
    assign w_nvd_ext    = {2'b00, nv_d};
    assign w_s_end      = w_nv_ext + C_RC2;
    // STREAM while s < num_vec + ROWS - 1, DRAIN afterwards.
    assign w_stream_end = w_nv_ext + C_ROWS_M1;

    // ------------------------------------------------------------------
    // Next-state logic. In LOAD_W the counter is the load step l; in
    // STREAM/DRAIN it is the step counter s.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_W;
                    cnt_d   = '0;
                    nv_d    = num_vec_i;
                end
            end
            LOAD_W: begin
                if (cnt_q == C_ROWS_M1) begin
                    cnt_d   = '0;
                    state_d = (nv_q == '0) ? DONE : STREAM;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            STREAM, DRAIN: begin
                if (cnt_q == w_s_end) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + C_ONE;
                    state_d = (cnt_d < w_stream_end) ? STREAM : DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so every output is a register
    // that already reflects the state it is reported for.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ctrl_d = 1'b0;
        wt_d   = '0;
        av_d   = '0;
        ai_d   = '0;
        ov_d   = '0;
        oi_d   = '0;
        w_diff = '0;

        if (state_d == LOAD_W) begin
            ctrl_d = 1'b1;
            // Reverse row order: row 0's weights are shifted in last.
            wt_d   = RAW_W'(C_ROWS_M1 - cnt_d);
        end

        if ((state_d == STREAM) || (state_d == DRAIN)) begin
            // Row r sees vector s-r: one cycle of skew per row.
            for (int r = 0; r < ROWS; r++) begin
                if (cnt_d >= CNT_W'(r)) begin
                    w_diff = cnt_d - CNT_W'(r);
                    if (w_diff < w_nvd_ext) begin
                        av_d[r] = 1'b1;
                        ai_d[r*IDX_W +: IDX_W] = w_diff[IDX_W-1:0];
                    end
                end
            end
            // Vector k leaves the bottom of column c at step k+ROWS+c.
            for (int c = 0; c < COLS; c++) begin
                if (cnt_d >= (C_ROWS + CNT_W'(c))) begin
                    w_diff = cnt_d - C_ROWS - CNT_W'(c);
                    if (w_diff < w_nvd_ext) begin
                        ov_d[c] = 1'b1;
                        oi_d[c*IDX_W +: IDX_W] = w_diff[IDX_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            wt_q    <= '0;
            av_q    <= '0;
            ai_q    <= '0;
            ov_q    <= '0;
            oi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
            wt_q    <= wt_d;
            av_q    <= av_d;
            ai_q    <= ai_d;
            ov_q    <= ov_d;
            oi_q    <= oi_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign array_control_o = ctrl_q;
    assign wt_rd_row_o     = wt_q;
    assign act_valid_o     = av_q;
    assign act_rd_idx_o    = ai_q;
    assign out_valid_o     = ov_q;
    assign out_idx_o       = oi_q;

endmodule
`default_nettype wire
